// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: walks the PC, fetches words over a req/gnt/rvalid
// handshake and hands them to decode in order through a 2-entry buffer.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic [10:0] instruction_part,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  r_state;
    logic [63:0] r_pc;
    logic [63:0] r_req_pc;
    logic [31:0] r_word [2];
    logic [63:0] r_wpc  [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic w_grant;
    logic w_push;
    logic w_pop;

    assign imem_req  = (r_state == S_REQ) && (r_count < 2'd2) && !reset;
    assign imem_addr = r_pc;
    assign w_grant   = imem_req && imem_gnt;
    // An rvalid outside WAIT is either a drained stale word or a protocol error.
    assign w_push    = (r_state == S_WAIT) && imem_rvalid;

    assign inst_valid       = (r_count != 2'd0) && !reset;
    assign w_pop            = inst_valid && inst_ready;
    assign inst             = inst_valid ? r_word[r_rd_ptr] : 32'h0;
    assign inst_pc          = inst_valid ? r_wpc[r_rd_ptr] : 64'h0;
    assign instruction_part = inst[31:21];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (redirect) begin
            // Flush wins over any same-cycle push/pop; an in-flight fetch becomes stale.
            r_pc     <= redirect_pc;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            case (r_state)
                S_REQ:   r_state <= w_grant ? S_DRAIN : S_REQ;
                S_WAIT,
                S_DRAIN: r_state <= imem_rvalid ? S_REQ : S_DRAIN;
                default: r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_grant) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + 64'd4;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT, S_DRAIN: begin
                    if (imem_rvalid) r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase

            if (w_push) begin
                r_word[r_wr_ptr] <= imem_rdata;
                r_wpc[r_wr_ptr]  <= r_req_pc;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory model with configurable latency feeds a
// scoreboard of {word, pc}; every word decode pops is checked against it.
module tb_instruction_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [10:0] instruction_part;
    logic        inst_ready;
    logic        redirect;
    logic [63:0] redirect_pc;

    instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .inst_valid       (inst_valid),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .instruction_part (instruction_part),
        .inst_ready       (inst_ready),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [95:0] exp_q[$];
    logic [63:0] gnt_log[$];

    bit          gnt_en     = 0;
    bit          inj_rvalid = 0;
    int          lat        = 1;
    bit          pend       = 0;
    bit          pend_stale = 0;
    logic [63:0] pend_addr  = '0;
    int          pend_cd    = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Memory: acts at negedge+1, one outstanding fetch, response 'lat' cycles after grant.
    initial begin
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        forever begin
            @(negedge clk); #1;
            imem_gnt = 0; imem_rvalid = 0; imem_rdata = $urandom;
            if (reset) begin
                pend = 0;
                inj_rvalid = 0;
            end else begin
                if (pend) begin
                    n_checks++;
                    if (imem_req !== 1'b0)
                        $display("FAIL single_outstanding: imem_req=%b want 0", imem_req);
                    else
                        n_pass++;
                    if (pend_cd == 0) begin
                        imem_rvalid = 1;
                        imem_rdata  = mem_word(pend_addr);
                        if (!pend_stale) exp_q.push_back({imem_rdata, pend_addr});
                        pend = 0;
                    end else begin
                        pend_cd--;
                    end
                end else if (inj_rvalid) begin
                    imem_rvalid = 1;
                    imem_rdata  = 32'hDEAD_BEEF;
                    inj_rvalid  = 0;
                end
                if (imem_req && gnt_en && !pend) begin
                    imem_gnt   = 1;
                    pend       = 1;
                    pend_stale = 0;
                    pend_addr  = imem_addr;
                    pend_cd    = lat - 1;
                    gnt_log.push_back(imem_addr);
                end
            end
        end
    end

    // Scoreboard monitor: flush on reset/redirect, otherwise compare each pop.
    initial begin
        logic [95:0] e;
        forever begin
            @(negedge clk); #2;
            if (reset || redirect) begin
                exp_q.delete();
                if (pend) pend_stale = 1;
            end else if (inst_valid && inst_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pop_unexpected: inst=%h pc=%h with no word expected", inst,
                             inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (inst !== e[95:64] || inst_pc !== e[63:0] ||
                        instruction_part !== e[95:85])
                        $display("FAIL pop_word: got %h@%h part %h want %h@%h part %h", inst,
                                 inst_pc, instruction_part, e[95:64], e[63:0], e[95:85]);
                    else
                        n_pass++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic settle();
        bit done = 0;
        inst_ready = 1; gnt_en = 0; inj_rvalid = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk); #3;
            if (!pend && !inst_valid && exp_q.size() == 0) done = 1;
        end
        n_checks++;
        if (!done) $display("FAIL settle: pend=%b valid=%b left=%0d want idle", pend,
                            inst_valid, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #3;
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0)
            $display("FAIL reset_outputs: req=%b valid=%b inst=%h want 0 0 0", imem_req,
                     inst_valid, inst);
        else n_pass++;
        @(negedge clk);
        reset = 0;
        #3;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC || inst_valid !== 1'b0)
            $display("FAIL first_req: req=%b addr=%h valid=%b want 1 %h 0", imem_req,
                     imem_addr, inst_valid, RST_PC);
        else n_pass++;
    endtask

    task automatic test_stream();
        gnt_log.delete();
        inst_ready = 1;
        lat = 1;
        @(negedge clk);
        gnt_en = 1;
        @(negedge clk); #3;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL stream_t1: valid=%b req=%b want 0 0", inst_valid, imem_req);
        else n_pass++;
        @(negedge clk); #3;
        n_checks++;
        if (inst_valid !== 1'b1 || imem_req !== 1'b1 || inst_pc !== RST_PC)
            $display("FAIL stream_t2: valid=%b req=%b pc=%h want 1 1 %h", inst_valid,
                     imem_req, inst_pc, RST_PC);
        else n_pass++;
        repeat (4) @(negedge clk);
        #3;
        n_checks++;
        if (gnt_log.size() < 3)
            $display("FAIL stream_grants: got %0d grants want >=3", gnt_log.size());
        else if (gnt_log[0] !== RST_PC || gnt_log[1] !== RST_PC + 4 ||
                 gnt_log[2] !== RST_PC + 8)
            $display("FAIL stream_addrs: got %h %h %h want %h %h %h", gnt_log[0], gnt_log[1],
                     gnt_log[2], RST_PC, RST_PC + 4, RST_PC + 8);
        else n_pass++;
        settle();
    endtask

    task automatic test_backpressure();
        inst_ready = 0; lat = 1; gnt_en = 1;
        repeat (8) @(negedge clk);
        #3;
        n_checks++;
        if (inst_valid !== 1'b1 || imem_req !== 1'b0 || exp_q.size() != 2)
            $display("FAIL bp_full: valid=%b req=%b words=%0d want 1 0 2", inst_valid,
                     imem_req, exp_q.size());
        else n_pass++;
        @(negedge clk);
        inj_rvalid = 1;
        repeat (2) @(negedge clk);
        #3;
        n_checks++;
        if (exp_q.size() == 0)
            $display("FAIL bp_hold: no expected head word");
        else if (inst !== exp_q[0][95:64] || inst_pc !== exp_q[0][63:0] || imem_req !== 1'b0)
            $display("FAIL bp_hold: got %h@%h req=%b want %h@%h req=0", inst, inst_pc,
                     imem_req, exp_q[0][95:64], exp_q[0][63:0]);
        else n_pass++;
        @(negedge clk);
        inst_ready = 1;
        @(negedge clk);
        inst_ready = 0;
        #3;
        n_checks++;
        if (imem_req !== 1'b1)
            $display("FAIL bp_req_after_pop: req=%b want 1", imem_req);
        else n_pass++;
        repeat (4) @(negedge clk);
        settle();
    endtask

    task automatic test_redirect_wait();
        gnt_log.delete();
        inst_ready = 0; lat = 3; gnt_en = 1;
        for (int i = 0; i < 30 && gnt_log.size() < 2; i++) begin
            @(negedge clk); #3;
        end
        @(negedge clk);
        redirect = 1; redirect_pc = 64'h2000;
        gnt_log.delete();
        @(negedge clk);
        redirect = 0;
        #3;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL rw_r1: valid=%b req=%b want 0 0", inst_valid, imem_req);
        else n_pass++;
        inst_ready = 1;
        for (int i = 0; i < 20 && gnt_log.size() == 0; i++) begin
            @(negedge clk); #3;
        end
        n_checks++;
        if (gnt_log.size() == 0 || gnt_log[0] !== 64'h2000)
            $display("FAIL rw_target: grants=%0d first=%h want 2000", gnt_log.size(),
                     gnt_log.size() ? gnt_log[0] : 64'h0);
        else n_pass++;
        settle();
    endtask

    task automatic test_redirect_grant();
        bit hit = 0;
        inst_ready = 1;
        @(negedge clk);
        redirect = 1; redirect_pc = RST_PC;
        @(negedge clk);
        redirect = 0;
        gnt_log.delete(); lat = 1; gnt_en = 1;
        #3;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC)
            $display("FAIL rg_r1: req=%b addr=%h want 1 %h", imem_req, imem_addr, RST_PC);
        else n_pass++;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == RST_PC + 8) begin
                redirect = 1; redirect_pc = 64'h3000; hit = 1;
            end
        end
        @(negedge clk);
        redirect = 0;
        #3;
        n_checks++;
        if (!hit || imem_req !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL rg_drain: hit=%b req=%b valid=%b want 1 0 0", hit, imem_req,
                     inst_valid);
        else n_pass++;
        for (int i = 0; i < 20 && gnt_log.size() < 4; i++) begin
            @(negedge clk); #3;
        end
        n_checks++;
        if (gnt_log.size() < 4)
            $display("FAIL rg_grants: got %0d grants want 4", gnt_log.size());
        else if (gnt_log[2] !== RST_PC + 8 || gnt_log[3] !== 64'h3000)
            $display("FAIL rg_addrs: got %h %h want %h 3000", gnt_log[2], gnt_log[3],
                     RST_PC + 8);
        else n_pass++;
        settle();
    endtask

    task automatic test_redirect_full();
        inst_ready = 0; lat = 1; gnt_en = 1;
        repeat (6) @(negedge clk);
        @(negedge clk);
        redirect = 1; redirect_pc = 64'h4000; inst_ready = 1; inj_rvalid = 1; gnt_en = 0;
        gnt_log.delete();
        @(negedge clk);
        redirect = 0; inst_ready = 0;
        #3;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h4000)
            $display("FAIL rf_flush: valid=%b req=%b addr=%h want 0 1 4000", inst_valid,
                     imem_req, imem_addr);
        else n_pass++;
        inst_ready = 1; gnt_en = 1;
        repeat (6) @(negedge clk);
        #3;
        n_checks++;
        if (gnt_log.size() == 0 || gnt_log[0] !== 64'h4000)
            $display("FAIL rf_target: grants=%0d want first 4000", gnt_log.size());
        else n_pass++;
        settle();
    endtask

    task automatic test_reset_mid();
        gnt_log.delete();
        inst_ready = 1; lat = 4; gnt_en = 1;
        for (int i = 0; i < 20 && gnt_log.size() == 0; i++) begin
            @(negedge clk); #3;
        end
        @(negedge clk);
        reset = 1;
        #3;
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL rm_during: req=%b valid=%b want 0 0", imem_req, inst_valid);
        else n_pass++;
        @(negedge clk); #3;
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== 64'h0)
            $display("FAIL rm_during2: req=%b valid=%b pc=%h want 0 0 0", imem_req,
                     inst_valid, inst_pc);
        else n_pass++;
        @(negedge clk);
        reset = 0; gnt_en = 0;
        #3;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC)
            $display("FAIL rm_restart: req=%b addr=%h want 1 %h", imem_req, imem_addr, RST_PC);
        else n_pass++;
        gnt_en = 1; lat = 1;
        repeat (6) @(negedge clk);
        settle();
    endtask

    initial begin
        reset = 1; inst_ready = 0; redirect = 0; redirect_pc = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_grant();
        test_redirect_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end producer for the LEGv8 single-issue datapath: generates the PC stream, fetches 32-bit instruction words from instruction memory over a request/grant/response handshake, and presents them in order to the decode stage through a 2-entry buffer. The decode stage, including the control unit that consumes `instruction_part`, pulls words through a valid/ready handshake. A taken branch from the execute stage redirects the PC. The redirect flushes buffered words and discards any stale in-flight response.

## Interface
- `RESET_PC`, 64'h0, PC fetched first after reset.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  64  fetch address. Stable while `imem_req` is high and not granted.
- `imem_gnt`  in  1  memory accepts the request this cycle when `imem_req` is also high.
- `imem_rvalid`  in  1  response word valid, one cycle. Arrives at least one cycle after grant.
- `imem_rdata`  in  32  response instruction word.
- `inst_valid`  out  1  buffer head valid.
- `inst`  out  32  buffer head instruction word.
- `inst_pc`  out  64  PC of buffer head.
- `instruction_part`  out  11  `inst[31:21]`, the opcode field for the control unit.
- `inst_ready`  in  1  decode consumes the head when `inst_valid` is also high.
- `redirect`  in  1  taken branch; highest priority.
- `redirect_pc`  in  64  branch target. Sampled when `redirect` is high.

## Operation
- State: `pc`, `req_pc` (address of the outstanding fetch), 2-entry FIFO of {word, pc}, 2-bit `count`, FSM.
- FSM states:
  - REQ: no fetch outstanding.
  - WAIT: fetch outstanding; response will be kept.
  - DRAIN: fetch outstanding; response will be discarded.
- At most one fetch is outstanding at any time.
- `imem_req` = (state==REQ) && (count<2) && !reset. `imem_addr` = `pc`.
- REQ, on grant:
  - `req_pc` <= `pc`; `pc` <= `pc`+4, wrapping modulo 2^64.
  - Go to WAIT.
- WAIT, on `imem_rvalid`:
  - Push {`imem_rdata`, `req_pc`}; go to REQ.
  - Overflow cannot occur: a request issues only when count<2, and nothing else pushes.
- DRAIN, on `imem_rvalid`: drop the word; go to REQ.
- Pop: when `inst_valid` && `inst_ready`, the FIFO advances. Push and pop in the same cycle leave `count` unchanged.
- Redirect has priority over all other events in the same cycle:
  - `pc` <= `redirect_pc`; FIFO flushed (`count` <= 0). A simultaneous pop or push is ignored.
  - From REQ with no grant: stay in REQ. The next cycle requests `redirect_pc`.
  - From REQ with a grant in the same cycle: the granted fetch is stale; go to DRAIN. `pc` still takes `redirect_pc` and is not incremented.
  - From WAIT: go to DRAIN. If `imem_rvalid` arrives in the same cycle, the word is dropped and the next state is REQ.
  - From DRAIN: stay in DRAIN (or go to REQ if `imem_rvalid` arrives). `pc` updates.
- An `imem_rvalid` in REQ is a protocol error. It is ignored.
- Reset:
  - `pc`=`RESET_PC`, `count`=0, state REQ.
  - `imem_req`=0 and `inst_valid`=0 during reset.
  - `inst`, `inst_pc`, `instruction_part` read 0 while empty.
  - Reset mid-fetch abandons the outstanding fetch. Memory is reset together with this block.

## Timing
- First `imem_req` is in the first cycle after `reset` deasserts, with `imem_addr`=`RESET_PC`.
- With grant at cycle t and `imem_rvalid` at t+1:
  - `inst_valid` rises at t+2 (FIFO output is registered; no bypass).
  - The next `imem_req` is at t+2.
- Peak throughput is one instruction per 2 cycles with single-cycle memory.
- A redirect at cycle r with no fetch outstanding puts `imem_addr`=`redirect_pc` at r+1.
- A redirect at cycle r with a fetch outstanding holds the request for `redirect_pc` until the cycle after the stale response.
- `inst_valid` drops at r+1 after any redirect.
- `inst`, `inst_pc` and `instruction_part` are held stable while `inst_valid` && !`inst_ready`.

## Test plan
- Reset, RESET_PC=0x1000, memory grants immediately and responds next cycle, `inst_ready`=1:
  - Fetch addresses are 0x1000, 0x1004, 0x1008.
  - `inst_pc` follows the same sequence, one every 2 cycles.
  - `instruction_part` = `imem_rdata[31:21]` for each word.
- `inst_ready`=0 backpressure:
  - After 2 words are buffered, `imem_req` stays low and head contents stay stable.
  - Raising `inst_ready` for one cycle pops one word and a new request issues the next cycle.
- Redirect to 0x2000 while in WAIT with a response 3 cycles later:
  - The stale word never appears on `inst`.
  - The next `imem_addr` is 0x2000, and `inst_valid` is low from r+1.
- Redirect in the same cycle as a grant to 0x1008:
  - FSM enters DRAIN; the 0x1008 response is discarded.
  - The following fetch is at `redirect_pc`, not 0x100C.
- Redirect with a full FIFO, the same cycle as a pop and an `imem_rvalid`: `count`=0 next cycle; the returned word is dropped.
- `reset` asserted mid-WAIT:
  - `imem_req`=0 and `inst_valid`=0 during reset.
  - After release, the first request is at RESET_PC.
